lsu: RTL and testbench
======================

// Module: lsu
// PURPOSE
//  Load/store unit between EX and the ME pipeline register. Takes the EX
//  address, store data and mem op, runs a req/ack transaction on the data bus,
//  and returns byte-lane-aligned, sign/zero-extended load data to ME.
//  Stalls the pipeline while a transaction is outstanding. Flags misaligned
//  accesses and bus timeouts.
// PARAMETERS
//  ADDR_W    32   byte address width (= `ADDR_W)
//  WORD_W    32   data word width; lane logic is fixed at 32, other values illegal
//  TIMEOUT   255  max cycles in ACCESS without i_bus_ack before a fault
// PORTS
//  clk          in   1          clock, rising edge
//  clr          in   1          reset, asynchronous, active-high
//  i_mem_op     in   MEM_OP_W   `MEM_OP_* code from EX; NONE = no access
//  i_addr       in   ADDR_W     byte address from EX ALU
//  i_wdata      in   WORD_W     store data, value in low bits
//  o_stall      out  1          hold all upstream pipeline registers
//  o_mem_read   out  WORD_W     extended load data to ME (i_mem_read)
//  o_fault      out  1          misalign/timeout flag, valid in DONE only
//  o_bus_req    out  1          bus request; held until ack or timeout
//  o_bus_we     out  1          1 = write
//  o_bus_addr   out  ADDR_W     word-aligned address ({i_addr[ADDR_W-1:2],2'b00})
//  o_bus_wdata  out  WORD_W     lane-replicated store data
//  o_bus_be     out  4          byte enables
//  i_bus_ack    in   1          completes the request this cycle
//  i_bus_rdata  in   WORD_W     read word, valid with i_bus_ack
// BEHAVIOUR
//  Reset (async, clr=1): state=IDLE; o_bus_req=0; o_mem_read=0; o_fault=0;
//   timeout counter=0. Takes effect immediately, including mid-ACCESS.
//   A pending request is dropped with no completion.
//  FSM states: IDLE, ACCESS, DONE.
//   IDLE: if op==NONE, stay; o_stall=0.
//     If op is misaligned (half with addr[0]=1; word with addr[1:0]!=0):
//     no bus request, latch o_fault=1 and o_mem_read=0, go to DONE;
//     o_stall=1 this cycle.
//     Else go to ACCESS; o_stall=1.
//   ACCESS: o_bus_req=1. Addr/we/wdata/be come from registers captured on
//     IDLE exit and stay stable. o_stall=1.
//     On i_bus_ack: latch extended read data (writes latch 0), o_fault=0,
//     go to DONE.
//     Else counter++. Counter reaching TIMEOUT with no ack: drop req,
//     o_fault=1, o_mem_read=0, go to DONE.
//     Ack in the same cycle as the timeout limit: ack wins, no fault.
//   DONE: o_stall=0; pipeline advances at the end of this cycle.
//     Always goes to IDLE. It never restarts on the op it sees, because that
//     op is the one just completed. o_mem_read and o_fault hold until the
//     next completion.
//  i_bus_ack outside ACCESS is ignored.
//  Bus latency: access completes 2 + (ack wait) cycles after IDLE
//   acceptance. With a zero-wait ack, each access costs 3 cycles
//   (IDLE, ACCESS, DONE).
//  Lanes (little-endian, lane = addr[1:0]):
//   byte: be = 4'b0001<<lane; wdata = {4{wdata[7:0]}}
//   half: be = 4'b0011<<{addr[1],1'b0}; wdata = {2{wdata[15:0]}}
//   word: be = 4'b1111; wdata = i_wdata
//   reads: be=4'b1111, we=0.
//  Load extraction: sh = i_bus_rdata >> (8*lane).
//   RD_BYTE/RD_HALF sign-extend sh[7:0]/sh[15:0].
//   RD_UBYTE/RD_UHALF zero-extend. RD_WORD passes through.
// TESTING
//  1. RD_BYTE addr 0x103, rdata 0x80FF_0102, ack after 2 waits ->
//     be=4'hF, bus_addr 0x100, o_mem_read=0xFFFF_FF80, o_fault=0,
//     stall high 4 cycles.
//  2. RD_UHALF addr 0x202, rdata 0x8001_1234, zero-wait ack ->
//     o_mem_read=0x0000_8001, 3-cycle access.
//  3. WR_BYTE addr 0x301, wdata 0xAB -> we=1, be=4'b0010,
//     bus_wdata=0xABAB_ABAB, o_mem_read=0.
//  4. RD_WORD addr 0x402 -> no bus_req, o_fault=1 in DONE, o_mem_read=0.
//  5. TIMEOUT=4, RD_WORD, never ack -> req drops after 4 ACCESS cycles,
//     o_fault=1. Repeat with ack on the 4th cycle -> no fault.
//  6. Assert clr mid-ACCESS -> bus_req=0 and stall=0 before the next edge.
//     A later ack is ignored and the FSM is in IDLE.

Source files
------------

// File: rtl/lsu_if.sv
// Data-bus side of the load/store unit: a single req/ack channel with
// word-aligned address, byte enables and lane-replicated write data.
interface lsu_if #(
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32
);
  logic              o_bus_req;
  logic              o_bus_we;
  logic [ADDR_W-1:0] o_bus_addr;
  logic [WORD_W-1:0] o_bus_wdata;
  logic [3:0]        o_bus_be;
  logic              i_bus_ack;
  logic [WORD_W-1:0] i_bus_rdata;

  modport master (
    output o_bus_req, o_bus_we, o_bus_addr, o_bus_wdata, o_bus_be,
    input  i_bus_ack, i_bus_rdata
  );

  modport slave (
    input  o_bus_req, o_bus_we, o_bus_addr, o_bus_wdata, o_bus_be,
    output i_bus_ack, i_bus_rdata
  );
endinterface

// File: rtl/lsu.sv
// Load/store unit between EX and ME: runs one bus transaction per memory op,
// stalls upstream while it is outstanding, and returns extended load data.
module lsu #(
  parameter int ADDR_W   = 32,
  parameter int WORD_W   = 32,
  parameter int TIMEOUT  = 255,
  parameter int MEM_OP_W = 4
) (
  input  logic                clk,
  input  logic                clr,
  input  logic [MEM_OP_W-1:0] i_mem_op,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic [WORD_W-1:0]   i_wdata,
  output logic                o_stall,
  output logic [WORD_W-1:0]   o_mem_read,
  output logic                o_fault,
  lsu_if.master               bus
);

  localparam logic [MEM_OP_W-1:0] OP_NONE     = MEM_OP_W'(0);
  localparam logic [MEM_OP_W-1:0] OP_RD_BYTE  = MEM_OP_W'(1);
  localparam logic [MEM_OP_W-1:0] OP_RD_HALF  = MEM_OP_W'(2);
  localparam logic [MEM_OP_W-1:0] OP_RD_WORD  = MEM_OP_W'(3);
  localparam logic [MEM_OP_W-1:0] OP_RD_UBYTE = MEM_OP_W'(4);
  localparam logic [MEM_OP_W-1:0] OP_RD_UHALF = MEM_OP_W'(5);
  localparam logic [MEM_OP_W-1:0] OP_WR_BYTE  = MEM_OP_W'(6);
  localparam logic [MEM_OP_W-1:0] OP_WR_HALF  = MEM_OP_W'(7);
  localparam logic [MEM_OP_W-1:0] OP_WR_WORD  = MEM_OP_W'(8);

  localparam int                CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  TO_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  function automatic logic [3:0] lane_be(input logic [MEM_OP_W-1:0] op, input logic [1:0] lane);
    case (op)
      OP_WR_BYTE: lane_be = 4'b0001 << lane;
      OP_WR_HALF: lane_be = 4'b0011 << {lane[1], 1'b0};
      default:    lane_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [WORD_W-1:0] lane_wdata(input logic [MEM_OP_W-1:0] op, input logic [WORD_W-1:0] d);
    case (op)
      OP_WR_BYTE: lane_wdata = {4{d[7:0]}};
      OP_WR_HALF: lane_wdata = {2{d[15:0]}};
      default:    lane_wdata = d;
    endcase
  endfunction

  function automatic logic [WORD_W-1:0] load_ext(input logic [MEM_OP_W-1:0] op, input logic [1:0] lane,
                                                 input logic [WORD_W-1:0] rdata);
    logic [WORD_W-1:0] sh;
    logic signed [7:0]  sb;
    logic signed [15:0] shw;
    sh  = rdata >> {lane, 3'b000};
    sb  = sh[7:0];
    shw = sh[15:0];
    case (op)
      OP_RD_BYTE:  load_ext = WORD_W'(sb);
      OP_RD_HALF:  load_ext = WORD_W'(shw);
      OP_RD_UBYTE: load_ext = WORD_W'(sh[7:0]);
      OP_RD_UHALF: load_ext = WORD_W'(sh[15:0]);
      default:     load_ext = rdata;
    endcase
  endfunction

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              start, misal_hit, ack_hit, to_hit;
  logic              op_half, op_word, op_wr, misal;

  logic [ADDR_W-1:0]   addr_p1;
  logic                we_p1;
  logic [WORD_W-1:0]   wdata_p1;
  logic [3:0]          be_p1;
  logic [MEM_OP_W-1:0] op_p1;
  logic [1:0]          lane_p1;

  assign op_half = (i_mem_op == OP_RD_HALF) || (i_mem_op == OP_RD_UHALF) || (i_mem_op == OP_WR_HALF);
  assign op_word = (i_mem_op == OP_RD_WORD) || (i_mem_op == OP_WR_WORD);
  assign op_wr   = (i_mem_op == OP_WR_BYTE) || (i_mem_op == OP_WR_HALF) || (i_mem_op == OP_WR_WORD);
  assign misal   = (op_half && i_addr[0]) || (op_word && (i_addr[1:0] != 2'b00));

  always_comb begin
    state_d   = state_q;
    o_stall   = 1'b0;
    start     = 1'b0;
    misal_hit = 1'b0;
    ack_hit   = 1'b0;
    to_hit    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_mem_op != OP_NONE) begin
          o_stall = 1'b1;
          state_d = misal ? S_DONE : S_ACCESS;
          misal_hit = misal;
          start     = !misal;
        end
      end
      S_ACCESS: begin
        o_stall = 1'b1;
        // ack checked first so an ack on the last allowed cycle is not a timeout
        if (bus.i_bus_ack) begin
          ack_hit = 1'b1;
          state_d = S_DONE;
        end else if (cnt_q == TO_LAST) begin
          to_hit  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // reset releases the pipeline immediately, not at the next edge
    if (clr) o_stall = 1'b0;
  end

  // Control stage: FSM, timeout counter and ME-facing results
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      o_mem_read <= '0;
      o_fault    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q != S_ACCESS) cnt_q <= '0;
      else if (!bus.i_bus_ack)  cnt_q <= cnt_q + 1'b1;
      if (misal_hit || to_hit) begin
        o_fault    <= 1'b1;
        o_mem_read <= '0;
      end else if (ack_hit) begin
        o_fault    <= 1'b0;
        o_mem_read <= we_p1 ? '0 : load_ext(op_p1, lane_p1, bus.i_bus_rdata);
      end
    end
  end

  // Request stage p1: bus fields captured on IDLE exit, stable through ACCESS
  always_ff @(posedge clk) begin
    if (start) begin
      addr_p1  <= {i_addr[ADDR_W-1:2], 2'b00};
      we_p1    <= op_wr;
      wdata_p1 <= lane_wdata(i_mem_op, i_wdata);
      be_p1    <= lane_be(i_mem_op, i_addr[1:0]);
      op_p1    <= i_mem_op;
      lane_p1  <= i_addr[1:0];
    end
  end

  assign bus.o_bus_req   = (state_q == S_ACCESS);
  assign bus.o_bus_we    = we_p1;
  assign bus.o_bus_addr  = addr_p1;
  assign bus.o_bus_wdata = wdata_p1;
  assign bus.o_bus_be    = be_p1;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: drives memory ops, plays the bus slave with a
// chosen number of wait states, and compares against hand-computed values.
module tb_lsu;

  localparam logic [3:0] OP_NONE     = 4'd0;
  localparam logic [3:0] OP_RD_BYTE  = 4'd1;
  localparam logic [3:0] OP_RD_HALF  = 4'd2;
  localparam logic [3:0] OP_RD_WORD  = 4'd3;
  localparam logic [3:0] OP_RD_UBYTE = 4'd4;
  localparam logic [3:0] OP_RD_UHALF = 4'd5;
  localparam logic [3:0] OP_WR_BYTE  = 4'd6;
  localparam logic [3:0] OP_WR_HALF  = 4'd7;
  localparam logic [3:0] OP_WR_WORD  = 4'd8;

  logic        clk = 1'b0;
  logic        clr;
  logic [3:0]  i_mem_op;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic        o_stall;
  logic [31:0] o_mem_read;
  logic        o_fault;

  int n_tests = 0;
  int n_fail  = 0;

  int          r_stall, r_acc;
  logic [31:0] r_addr, r_wdata, r_mem;
  logic [3:0]  r_be;
  logic        r_we, r_fault;

  lsu_if #(.ADDR_W(32), .WORD_W(32)) bus ();

  lsu #(.ADDR_W(32), .WORD_W(32), .TIMEOUT(4), .MEM_OP_W(4)) dut (
    .clk        (clk),
    .clr        (clr),
    .i_mem_op   (i_mem_op),
    .i_addr     (i_addr),
    .i_wdata    (i_wdata),
    .o_stall    (o_stall),
    .o_mem_read (o_mem_read),
    .o_fault    (o_fault),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Called on a falling edge; returns on a falling edge with the unit back in IDLE.
  // waits < 0 means the slave never acks.
  task automatic run_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int waits);
    bit done;
    done    = 1'b0;
    r_stall = 0;
    r_acc   = 0;
    r_mem   = 'x;
    r_fault = 1'bx;
    i_mem_op = op;
    i_addr   = addr;
    i_wdata  = wdata;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      #1;
      if (!o_stall) begin
        done    = 1'b1;
        r_mem   = o_mem_read;
        r_fault = o_fault;
      end else begin
        r_stall++;
        if (bus.o_bus_req) begin
          r_acc++;
          r_addr  = bus.o_bus_addr;
          r_we    = bus.o_bus_we;
          r_be    = bus.o_bus_be;
          r_wdata = bus.o_bus_wdata;
          bus.i_bus_ack   = (waits >= 0) && (r_acc == waits + 1);
          bus.i_bus_rdata = rdata;
        end
        @(negedge clk);
        bus.i_bus_ack = 1'b0;
      end
    end
    chk("done_in_budget", 32'(done), 32'd1);
    i_mem_op = OP_NONE;
    @(negedge clk);
  endtask

  initial begin
    clr = 1'b1;
    i_mem_op = OP_NONE;
    i_addr = '0;
    i_wdata = '0;
    bus.i_bus_ack = 1'b0;
    bus.i_bus_rdata = '0;
    #1;
    chk("rst_req",   32'(bus.o_bus_req), 32'd0);
    chk("rst_stall", 32'(o_stall), 32'd0);
    chk("rst_mem",   o_mem_read, 32'h0);
    chk("rst_fault", 32'(o_fault), 32'd0);
    @(negedge clk);
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);

    // signed byte load, lane 3, two wait states
    run_op(OP_RD_BYTE, 32'h103, 32'h0, 32'h80FF_0102, 2);
    chk("rdb_be",    32'(r_be), 32'hF);
    chk("rdb_addr",  r_addr, 32'h100);
    chk("rdb_we",    32'(r_we), 32'd0);
    chk("rdb_mem",   r_mem, 32'hFFFF_FF80);
    chk("rdb_fault", 32'(r_fault), 32'd0);
    chk("rdb_stall", 32'(r_stall), 32'd4);
    chk("rdb_acc",   32'(r_acc), 32'd3);

    // unsigned half, upper lane, zero-wait
    run_op(OP_RD_UHALF, 32'h202, 32'h0, 32'h8001_1234, 0);
    chk("rduh_mem",   r_mem, 32'h0000_8001);
    chk("rduh_stall", 32'(r_stall), 32'd2);
    chk("rduh_addr",  r_addr, 32'h200);

    // signed half, upper lane
    run_op(OP_RD_HALF, 32'h002, 32'h0, 32'h8001_1234, 1);
    chk("rdh_mem", r_mem, 32'hFFFF_8001);

    // unsigned and signed byte from lane 2
    run_op(OP_RD_UBYTE, 32'h102, 32'h0, 32'h80FF_0102, 0);
    chk("rdub_mem", r_mem, 32'h0000_00FF);
    run_op(OP_RD_BYTE, 32'h102, 32'h0, 32'h80FF_0102, 0);
    chk("rdb2_mem", r_mem, 32'hFFFF_FFFF);

    run_op(OP_RD_WORD, 32'h010, 32'h0, 32'h1234_5678, 0);
    chk("rdw_mem", r_mem, 32'h1234_5678);

    // byte write, lane 1
    run_op(OP_WR_BYTE, 32'h301, 32'h0000_00AB, 32'hDEAD_BEEF, 0);
    chk("wrb_we",    32'(r_we), 32'd1);
    chk("wrb_be",    32'(r_be), 32'b0010);
    chk("wrb_wdata", r_wdata, 32'hABAB_ABAB);
    chk("wrb_addr",  r_addr, 32'h300);
    chk("wrb_mem",   r_mem, 32'h0);

    run_op(OP_WR_HALF, 32'h006, 32'h1234_5678, 32'hDEAD_BEEF, 0);
    chk("wrh_be",    32'(r_be), 32'b1100);
    chk("wrh_wdata", r_wdata, 32'h5678_5678);
    chk("wrh_addr",  r_addr, 32'h004);

    run_op(OP_WR_WORD, 32'h008, 32'hCAFE_F00D, 32'h0, 0);
    chk("wrw_be",    32'(r_be), 32'hF);
    chk("wrw_wdata", r_wdata, 32'hCAFE_F00D);

    // load something nonzero so the misalign clear of o_mem_read is visible
    run_op(OP_RD_WORD, 32'h010, 32'h0, 32'h1111_2222, 0);
    run_op(OP_RD_WORD, 32'h402, 32'h0, 32'h5555_5555, 0);
    chk("misw_acc",   32'(r_acc), 32'd0);
    chk("misw_fault", 32'(r_fault), 32'd1);
    chk("misw_mem",   r_mem, 32'h0);
    chk("misw_stall", 32'(r_stall), 32'd1);

    run_op(OP_WR_HALF, 32'h005, 32'h0, 32'h0, 0);
    chk("mish_acc",   32'(r_acc), 32'd0);
    chk("mish_fault", 32'(r_fault), 32'd1);

    // byte ops are never misaligned
    run_op(OP_RD_UBYTE, 32'h003, 32'h0, 32'h7700_0000, 0);
    chk("b3_fault", 32'(r_fault), 32'd0);
    chk("b3_mem",   r_mem, 32'h0000_0077);

    // timeout: four ACCESS cycles then fault
    run_op(OP_RD_WORD, 32'h020, 32'h0, 32'h0, -1);
    chk("to_acc",   32'(r_acc), 32'd4);
    chk("to_fault", 32'(r_fault), 32'd1);
    chk("to_mem",   r_mem, 32'h0);

    // ack on the limit cycle wins
    run_op(OP_RD_WORD, 32'h020, 32'h0, 32'hA5A5_0F0F, 3);
    chk("toack_acc",   32'(r_acc), 32'd4);
    chk("toack_fault", 32'(r_fault), 32'd0);
    chk("toack_mem",   r_mem, 32'hA5A5_0F0F);

    // reset in the middle of ACCESS
    i_mem_op = OP_RD_WORD;
    i_addr   = 32'h040;
    @(negedge clk);
    #1;
    chk("clr_pre_req", 32'(bus.o_bus_req), 32'd1);
    clr = 1'b1;
    #1;
    chk("clr_req",   32'(bus.o_bus_req), 32'd0);
    chk("clr_stall", 32'(o_stall), 32'd0);
    i_mem_op = OP_NONE;
    @(negedge clk);
    clr = 1'b0;
    bus.i_bus_ack   = 1'b1;
    bus.i_bus_rdata = 32'h5A5A_5A5A;
    @(negedge clk);
    bus.i_bus_ack = 1'b0;
    #1;
    chk("clr_post_req",   32'(bus.o_bus_req), 32'd0);
    chk("clr_post_stall", 32'(o_stall), 32'd0);
    chk("clr_post_mem",   o_mem_read, 32'h0);
    chk("clr_post_fault", 32'(o_fault), 32'd0);

    // unit still usable after the aborted access
    @(negedge clk);
    run_op(OP_RD_UHALF, 32'h000, 32'h0, 32'h8001_1234, 0);
    chk("after_clr_mem", r_mem, 32'h0000_1234);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
